// File: rtl/schedule_queue.sv
// Out-of-order issue window for Raisin64: age-ordered, shift-compacted, one issue per cycle.
// The decoded type bit arrives on op_type because "type" is a reserved word in SystemVerilog.
module schedule_queue #(
    parameter int DEPTH   = 4,
    parameter int NUM_ALU = 2,
    parameter int RN_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       op_type,
    input  logic [2:0]                 unit,
    input  logic [RN_W-1:0]            r1_in_rn,
    input  logic [RN_W-1:0]            r2_in_rn,
    input  logic [RN_W-1:0]            rd_in_rn,
    input  logic [RN_W-1:0]            rd2_in_rn,
    input  logic                       flush,
    input  logic [(1<<RN_W)-1:0]       reg_busy,
    input  logic [NUM_ALU-1:0]         alu_busy,
    input  logic                       advint_busy,
    input  logic                       memunit_busy,
    input  logic                       branch_busy,
    output logic [NUM_ALU-1:0]         alu_en,
    output logic                       advint_en,
    output logic                       memunit_en,
    output logic                       branch_en,
    output logic [RN_W-1:0]            rd_out_rn,
    output logic [RN_W-1:0]            rd2_out_rn,
    output logic                       inst_issued,
    output logic                       illegal_op,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {CLS_ALU, CLS_ADVINT, CLS_MEM, CLS_BR} cls_e;

    typedef struct packed {
        cls_e            cls;
        logic [RN_W-1:0] r1;
        logic [RN_W-1:0] r2;
        logic [RN_W-1:0] rd;
        logic [RN_W-1:0] rd2;
    } entry_t;

    function automatic logic writes_reg(entry_t e, logic [RN_W-1:0] rn);
        return (e.rd == rn) || (e.cls == CLS_ADVINT && e.rd2 == rn);
    endfunction

    function automatic logic reads_reg(entry_t e, logic [RN_W-1:0] rn);
        return (e.r1 == rn) || (e.r2 == rn);
    endfunction

    // RAW/WAW against the older entry's destinations, WAR against its sources.
    function automatic logic conflicts(entry_t older, entry_t young);
        logic c;
        c = writes_reg(older, young.r1) || writes_reg(older, young.r2) ||
            writes_reg(older, young.rd) || reads_reg(older, young.rd);
        if (young.cls == CLS_ADVINT)
            c = c || writes_reg(older, young.rd2) || reads_reg(older, young.rd2);
        return c;
    endfunction

    entry_t             win     [DEPTH];
    entry_t             win_nxt [DEPTH];
    entry_t             new_entry;
    entry_t             sel_entry;
    logic               in_illegal;
    logic               accept;
    logic               enq_write;
    logic               issue;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [DEPTH-1:0]   elig;
    logic [NUM_ALU-1:0] alu_pick;
    logic [3:0]         cls_free;
    logic [CNT_W-1:0]   wr_slot;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        new_entry.cls = CLS_ALU;
        new_entry.r1  = r1_in_rn;
        new_entry.r2  = r2_in_rn;
        new_entry.rd  = rd_in_rn;
        new_entry.rd2 = rd2_in_rn;
        in_illegal    = 1'b0;
        if (unit == 3'd7)
            new_entry.cls = CLS_BR;
        else if (unit[2]) begin
            if (op_type)
                new_entry.cls = CLS_MEM;
            else if (unit == 3'd4)
                new_entry.cls = CLS_ADVINT;
            else
                in_illegal = 1'b1;
        end
    end

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign accept    = in_valid && in_ready && !flush;
    assign enq_write = accept && !in_illegal;

    // Indexed by cls_e.
    assign cls_free = {!branch_busy, !memunit_busy, !advint_busy, !(&alu_busy)};

    always_comb begin
        alu_pick = '0;
        for (int k = NUM_ALU-1; k >= 0; k--)
            if (!alu_busy[k]) alu_pick = NUM_ALU'(1) << k;
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                elig[i] = cls_free[win[i].cls] && !reg_busy[win[i].r1] && !reg_busy[win[i].r2] &&
                          !(win[i].cls == CLS_BR && i != 0);
                for (int j = 0; j < i; j++) begin
                    if (conflicts(win[j], win[i]) || win[j].cls == CLS_BR ||
                        (win[j].cls == CLS_MEM && win[i].cls == CLS_MEM))
                        elig[i] = 1'b0;
                end
            end
        end
    end

    // Descending scan so the oldest eligible entry wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_entry = win[0];
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_entry = win[i];
            end
        end
    end

    assign issue   = sel_valid && !flush;
    assign wr_slot = count - CNT_W'(issue);

    always_comb begin
        win_nxt = win;
        for (int i = 0; i < DEPTH-1; i++)
            if (issue && i >= int'(sel_idx)) win_nxt[i] = win[i+1];
        for (int i = 0; i < DEPTH; i++)
            if (enq_write && i == int'(wr_slot)) win_nxt[i] = new_entry;
    end

    // NOTE: the payload array has no reset; a slot is only read when its index is below count, which does reset.
    always_ff @(posedge clk) begin
        win <= win_nxt;
    end

    // NOTE: sequential state uses <= only, so each register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            alu_en     <= '0;
            advint_en  <= 1'b0;
            memunit_en <= 1'b0;
            branch_en  <= 1'b0;
            rd_out_rn  <= '0;
            rd2_out_rn <= '0;
            illegal_op <= 1'b0;
        end else begin
            alu_en     <= '0;
            advint_en  <= 1'b0;
            memunit_en <= 1'b0;
            branch_en  <= 1'b0;
            illegal_op <= accept && in_illegal;
            if (flush)
                count <= '0;
            else
                count <= count + CNT_W'(enq_write) - CNT_W'(issue);
            if (issue) begin
                rd_out_rn <= sel_entry.rd;
                unique case (sel_entry.cls)
                    CLS_ALU:    alu_en <= alu_pick;
                    CLS_ADVINT: begin
                        advint_en  <= 1'b1;
                        rd2_out_rn <= sel_entry.rd2;
                    end
                    CLS_MEM:    memunit_en <= 1'b1;
                    CLS_BR:     branch_en <= 1'b1;
                endcase
            end
        end
    end

    assign inst_issued = (|alu_en) | advint_en | memunit_en | branch_en;

endmodule

// File: tb/tb_schedule_queue.sv
// Self-checking bench for schedule_queue: directed scenarios with hand-derived values,
// then randomized traffic checked against a queue-based reference model.
module tb_schedule_queue;
    localparam int DEPTH   = 4;
    localparam int NUM_ALU = 2;
    localparam int RN_W    = 6;
    localparam int NREG    = 1 << RN_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid, in_ready, op_type, flush;
    logic [2:0]           unit;
    logic [RN_W-1:0]      r1_in_rn, r2_in_rn, rd_in_rn, rd2_in_rn;
    logic [NREG-1:0]      reg_busy;
    logic [NUM_ALU-1:0]   alu_busy, alu_en;
    logic                 advint_busy, memunit_busy, branch_busy;
    logic                 advint_en, memunit_en, branch_en, inst_issued, illegal_op;
    logic [RN_W-1:0]      rd_out_rn, rd2_out_rn;
    logic [$clog2(DEPTH+1)-1:0] count;

    int total = 0;
    int bad   = 0;

    schedule_queue #(.DEPTH(DEPTH), .NUM_ALU(NUM_ALU), .RN_W(RN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_type(op_type), .unit(unit), .r1_in_rn(r1_in_rn), .r2_in_rn(r2_in_rn),
        .rd_in_rn(rd_in_rn), .rd2_in_rn(rd2_in_rn), .flush(flush), .reg_busy(reg_busy),
        .alu_busy(alu_busy), .advint_busy(advint_busy), .memunit_busy(memunit_busy),
        .branch_busy(branch_busy), .alu_en(alu_en), .advint_en(advint_en),
        .memunit_en(memunit_en), .branch_en(branch_en), .rd_out_rn(rd_out_rn),
        .rd2_out_rn(rd2_out_rn), .inst_issued(inst_issued), .illegal_op(illegal_op),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain age-ordered queue of pending ops.
    typedef enum {M_ALU, M_ADV, M_MEM, M_BR, M_BAD} mcls_e;
    typedef struct {
        mcls_e cls;
        int    r1, r2, rd, rd2;
    } mop_t;

    mop_t               q[$];
    logic [NUM_ALU-1:0] e_alu;
    logic               e_adv, e_mem, e_br, e_ill;
    logic [RN_W-1:0]    e_rd, e_rd2;

    function automatic mcls_e decode(logic t, logic [2:0] u);
        if (u <= 3'd3) return M_ALU;
        if (u == 3'd7) return M_BR;
        if (t)         return M_MEM;
        if (u == 3'd4) return M_ADV;
        return M_BAD;
    endfunction

    task automatic model_reset();
        q.delete();
        e_alu = '0; e_adv = 0; e_mem = 0; e_br = 0; e_ill = 0; e_rd = '0; e_rd2 = '0;
    endtask

    // Computes what the next clock edge should produce from the current inputs.
    task automatic model_step();
        bit   wset [NREG];
        bit   rset [NREG];
        bit   seen_br, seen_mem, ok, free, acc;
        int   pick;
        mop_t n;
        n.cls = decode(op_type, unit);
        n.r1 = int'(r1_in_rn); n.r2 = int'(r2_in_rn); n.rd = int'(rd_in_rn); n.rd2 = int'(rd2_in_rn);
        e_alu = '0; e_adv = 0; e_mem = 0; e_br = 0; e_ill = 0;
        if (flush) begin
            q.delete();
            return;
        end
        for (int k = 0; k < NREG; k++) begin wset[k] = 0; rset[k] = 0; end
        seen_br = 0; seen_mem = 0; pick = -1;
        acc = in_valid && (q.size() < DEPTH);
        for (int i = 0; i < q.size(); i++) begin
            case (q[i].cls)
                M_ALU:   free = (alu_busy != '1);
                M_ADV:   free = !advint_busy;
                M_MEM:   free = !memunit_busy;
                default: free = !branch_busy;
            endcase
            ok = free && !reg_busy[q[i].r1] && !reg_busy[q[i].r2];
            if (wset[q[i].r1] || wset[q[i].r2] || wset[q[i].rd] || rset[q[i].rd]) ok = 0;
            if (q[i].cls == M_ADV && (wset[q[i].rd2] || rset[q[i].rd2])) ok = 0;
            if (seen_br || (q[i].cls == M_BR && i != 0)) ok = 0;
            if (q[i].cls == M_MEM && seen_mem) ok = 0;
            if (ok && pick < 0) pick = i;
            wset[q[i].rd] = 1;
            if (q[i].cls == M_ADV) wset[q[i].rd2] = 1;
            rset[q[i].r1] = 1;
            rset[q[i].r2] = 1;
            if (q[i].cls == M_BR)  seen_br = 1;
            if (q[i].cls == M_MEM) seen_mem = 1;
        end
        if (pick >= 0) begin
            case (q[pick].cls)
                M_ALU: begin
                    for (int k = 0; k < NUM_ALU; k++)
                        if (!alu_busy[k] && e_alu == '0) e_alu[k] = 1'b1;
                end
                M_ADV: begin e_adv = 1; e_rd2 = RN_W'(q[pick].rd2); end
                M_MEM: e_mem = 1;
                default: e_br = 1;
            endcase
            e_rd = RN_W'(q[pick].rd);
            q.delete(pick);
        end
        if (acc) begin
            if (n.cls == M_BAD) e_ill = 1;
            else q.push_back(n);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic t, input logic [2:0] u, input int a, input int b, input int d, input int d2);
        in_valid = 1'b1; op_type = t; unit = u;
        r1_in_rn = RN_W'(a); r2_in_rn = RN_W'(b); rd_in_rn = RN_W'(d); rd2_in_rn = RN_W'(d2);
    endtask

    task automatic clear_busy();
        alu_busy = '0; advint_busy = 0; memunit_busy = 0; branch_busy = 0; reg_busy = '0;
    endtask

    task automatic test_reset();
        total++; if ({alu_en, advint_en, memunit_en, branch_en, inst_issued, illegal_op} !== '0) begin
            bad++; $display("FAIL reset_pulses got=%b want=0", {alu_en, advint_en, memunit_en, branch_en, inst_issued, illegal_op}); end
        total++; if (count !== 0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_count got count=%0d ready=%b want 0/1", count, in_ready); end
        total++; if (rd_out_rn !== 0 || rd2_out_rn !== 0) begin
            bad++; $display("FAIL reset_rd got rd=%0d rd2=%0d want 0/0", rd_out_rn, rd2_out_rn); end
    endtask

    task automatic test_single_alu();
        put(1'b0, 3'd0, 1, 2, 3, 0);
        tick();
        in_valid = 1'b0;
        total++; if (count !== 1 || alu_en !== 2'b00) begin
            bad++; $display("FAIL single_accept got count=%0d alu_en=%b want 1/00", count, alu_en); end
        tick();
        total++; if (alu_en !== 2'b01 || rd_out_rn !== 3 || inst_issued !== 1'b1) begin
            bad++; $display("FAIL single_issue got alu_en=%b rd=%0d iss=%b want 01/3/1", alu_en, rd_out_rn, inst_issued); end
        total++; if (count !== 0) begin
            bad++; $display("FAIL single_count got=%0d want=0", count); end
        tick();
        total++; if (alu_en !== 2'b00) begin
            bad++; $display("FAIL single_one_pulse got=%b want=00", alu_en); end
    endtask

    task automatic test_alu_busy();
        alu_busy = 2'b11;
        put(1'b0, 3'd1, 1, 2, 3, 0); tick();
        put(1'b0, 3'd2, 4, 5, 6, 0); tick();
        in_valid = 1'b0;
        tick();
        total++; if (count !== 2 || alu_en !== 2'b00) begin
            bad++; $display("FAIL alu_all_busy got count=%0d alu_en=%b want 2/00", count, alu_en); end
        alu_busy = 2'b01;
        tick();
        total++; if (alu_en !== 2'b10 || rd_out_rn !== 3 || count !== 1) begin
            bad++; $display("FAIL alu_first got alu_en=%b rd=%0d count=%0d want 10/3/1", alu_en, rd_out_rn, count); end
        tick();
        total++; if (alu_en !== 2'b10 || rd_out_rn !== 6 || count !== 0) begin
            bad++; $display("FAIL alu_second got alu_en=%b rd=%0d count=%0d want 10/6/0", alu_en, rd_out_rn, count); end
        alu_busy = 2'b00;
        tick();
    endtask

    task automatic test_out_of_order();
        memunit_busy = 1'b1;
        put(1'b1, 3'd4, 1, 2, 5, 0); tick();
        put(1'b0, 3'd0, 5, 0, 6, 0); tick();
        put(1'b0, 3'd0, 7, 0, 8, 0); tick();
        in_valid = 1'b0;
        total++; if (inst_issued !== 1'b0 || count !== 3) begin
            bad++; $display("FAIL ooo_blocked got iss=%b count=%0d want 0/3", inst_issued, count); end
        tick();
        total++; if (alu_en !== 2'b01 || rd_out_rn !== 8 || count !== 2) begin
            bad++; $display("FAIL ooo_young got alu_en=%b rd=%0d count=%0d want 01/8/2", alu_en, rd_out_rn, count); end
        tick();
        total++; if (inst_issued !== 1'b0 || count !== 2) begin
            bad++; $display("FAIL ooo_hold got iss=%b count=%0d want 0/2", inst_issued, count); end
        memunit_busy = 1'b0;
        tick();
        total++; if (memunit_en !== 1'b1 || rd_out_rn !== 5) begin
            bad++; $display("FAIL ooo_mem got mem_en=%b rd=%0d want 1/5", memunit_en, rd_out_rn); end
        tick();
        total++; if (alu_en !== 2'b01 || rd_out_rn !== 6 || count !== 0) begin
            bad++; $display("FAIL ooo_dep got alu_en=%b rd=%0d count=%0d want 01/6/0", alu_en, rd_out_rn, count); end
    endtask

    task automatic test_advint();
        put(1'b0, 3'd4, 1, 2, 9, 10); tick();
        in_valid = 1'b0;
        tick();
        total++; if (advint_en !== 1'b1 || rd_out_rn !== 9 || rd2_out_rn !== 10) begin
            bad++; $display("FAIL advint_issue got en=%b rd=%0d rd2=%0d want 1/9/10", advint_en, rd_out_rn, rd2_out_rn); end
        put(1'b0, 3'd3, 1, 2, 12, 13); tick();
        in_valid = 1'b0;
        tick();
        total++; if (alu_en !== 2'b01 || rd_out_rn !== 12 || rd2_out_rn !== 10) begin
            bad++; $display("FAIL advint_rd2_hold got alu_en=%b rd=%0d rd2=%0d want 01/12/10", alu_en, rd_out_rn, rd2_out_rn); end
    endtask

    task automatic test_full_flush();
        alu_busy = 2'b11; advint_busy = 1; memunit_busy = 1; branch_busy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            put(1'b0, 3'd0, 10+i, 20+i, 30+i, 0);
            tick();
        end
        total++; if (count !== DEPTH || in_ready !== 1'b0) begin
            bad++; $display("FAIL full got count=%0d ready=%b want 4/0", count, in_ready); end
        flush = 1'b1;
        tick();
        total++; if (count !== 0 || in_ready !== 1'b1 || inst_issued !== 1'b0) begin
            bad++; $display("FAIL flush_full got count=%0d ready=%b iss=%b want 0/1/0", count, in_ready, inst_issued); end
        flush = 1'b0;
        put(1'b0, 3'd0, 40, 41, 42, 0); tick();
        flush = 1'b1;
        put(1'b0, 3'd0, 43, 44, 45, 0); tick();
        total++; if (count !== 0) begin
            bad++; $display("FAIL flush_ignores_enq got count=%0d want=0", count); end
        flush = 1'b0; in_valid = 1'b0;
        clear_busy();
        tick();
        total++; if (inst_issued !== 1'b0 || count !== 0) begin
            bad++; $display("FAIL flush_no_issue got iss=%b count=%0d want 0/0", inst_issued, count); end
    endtask

    task automatic test_branch();
        branch_busy = 1'b1;
        put(1'b0, 3'd7, 21, 22, 20, 0); tick();
        put(1'b0, 3'd0, 1, 2, 3, 0); tick();
        in_valid = 1'b0;
        tick();
        total++; if (inst_issued !== 1'b0 || count !== 2) begin
            bad++; $display("FAIL br_blocks got iss=%b count=%0d want 0/2", inst_issued, count); end
        branch_busy = 1'b0;
        tick();
        total++; if (branch_en !== 1'b1 || alu_en !== 2'b00 || rd_out_rn !== 20) begin
            bad++; $display("FAIL br_issue got br=%b alu=%b rd=%0d want 1/00/20", branch_en, alu_en, rd_out_rn); end
        tick();
        total++; if (alu_en !== 2'b01 || branch_en !== 1'b0 || count !== 0) begin
            bad++; $display("FAIL br_then_alu got alu=%b br=%b count=%0d want 01/0/0", alu_en, branch_en, count); end
    endtask

    task automatic test_illegal();
        put(1'b0, 3'd5, 1, 2, 3, 0); tick();
        in_valid = 1'b0;
        total++; if (illegal_op !== 1'b1 || count !== 0 || inst_issued !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse got ill=%b count=%0d iss=%b want 1/0/0", illegal_op, count, inst_issued); end
        tick();
        total++; if (illegal_op !== 1'b0 || inst_issued !== 1'b0) begin
            bad++; $display("FAIL illegal_one_cycle got ill=%b iss=%b want 0/0", illegal_op, inst_issued); end
    endtask

    task automatic test_reset_midop();
        put(1'b0, 3'd0, 1, 2, 3, 0); tick();
        put(1'b0, 3'd0, 4, 5, 6, 0); tick();
        in_valid = 1'b0;
        total++; if (alu_en !== 2'b01 || count !== 1) begin
            bad++; $display("FAIL midop_pre got alu_en=%b count=%0d want 01/1", alu_en, count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (alu_en !== 2'b00 || count !== 0 || rd_out_rn !== 0) begin
            bad++; $display("FAIL midop_reset got alu_en=%b count=%0d rd=%0d want 00/0/0", alu_en, count, rd_out_rn); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            op_type   = 1'($urandom_range(0, 1));
            unit      = 3'($urandom_range(0, 7));
            r1_in_rn  = RN_W'($urandom_range(0, 7));
            r2_in_rn  = RN_W'($urandom_range(0, 7));
            rd_in_rn  = RN_W'($urandom_range(0, 7));
            rd2_in_rn = RN_W'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 39) == 0);
            alu_busy  = NUM_ALU'($urandom_range(0, (1 << NUM_ALU) - 1));
            advint_busy  = ($urandom_range(0, 3) == 0);
            memunit_busy = ($urandom_range(0, 3) == 0);
            branch_busy  = ($urandom_range(0, 3) == 0);
            reg_busy = '0;
            for (int k = 0; k < 8; k++) reg_busy[k] = ($urandom_range(0, 5) == 0);
            tick();
            total++; if ({alu_en, advint_en, memunit_en, branch_en} !== {e_alu, e_adv, e_mem, e_br}) begin
                bad++; $display("FAIL rnd_en cyc=%0d got=%b want=%b", c, {alu_en, advint_en, memunit_en, branch_en}, {e_alu, e_adv, e_mem, e_br}); end
            total++; if (rd_out_rn !== e_rd || rd2_out_rn !== e_rd2) begin
                bad++; $display("FAIL rnd_rd cyc=%0d got=%0d/%0d want=%0d/%0d", c, rd_out_rn, rd2_out_rn, e_rd, e_rd2); end
            total++; if (illegal_op !== e_ill) begin
                bad++; $display("FAIL rnd_illegal cyc=%0d got=%b want=%b", c, illegal_op, e_ill); end
            total++; if (int'(count) != q.size() || in_ready !== (q.size() < DEPTH)) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%b want=%0d", c, count, in_ready, q.size()); end
            total++; if (inst_issued !== ((|e_alu) | e_adv | e_mem | e_br)) begin
                bad++; $display("FAIL rnd_issued cyc=%0d got=%b", c, inst_issued); end
        end
        in_valid = 1'b0; flush = 1'b0;
        clear_busy();
    endtask

    initial begin
        in_valid = 0; op_type = 0; unit = '0; flush = 0;
        r1_in_rn = '0; r2_in_rn = '0; rd_in_rn = '0; rd2_in_rn = '0;
        clear_busy();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_alu();
        test_alu_busy();
        test_out_of_order();
        test_advint();
        test_full_flush();
        test_branch();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/schedule_queue.md
# schedule_queue

Parametrised out-of-order instruction scheduler for Raisin64. It buffers up to DEPTH decoded instructions in an age-ordered window and issues at most one per cycle. Each cycle it picks the oldest entry that is hazard-free and whose target unit class has a free unit, and dispatches it to NUM_ALU ALUs, the advanced-integer unit, the memory unit or the branch unit. It sits between decode and the execution units, in place of the single-slot in-order scheduler.

## Interface
- DEPTH, 4: window entries, 2..16
- NUM_ALU, 2: number of ALU instances, 1..4
- RN_W, 6: register-number width; register file has 2^RN_W registers
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  window can accept (count < DEPTH)
- type  in  1  decoded type bit
- unit  in  3  decoded unit field
- r1_in_rn, r2_in_rn  in  RN_W  source registers
- rd_in_rn, rd2_in_rn  in  RN_W  destination registers (rd2 meaningful only for advint)
- flush  in  1  synchronous window clear (branch mispredict)
- reg_busy  in  2^RN_W  per-register pending-write scoreboard
- alu_busy  in  NUM_ALU  per-ALU busy
- advint_busy, memunit_busy, branch_busy  in  1  unit busy
- alu_en  out  NUM_ALU  one-cycle issue pulse per ALU
- advint_en, memunit_en, branch_en  out  1  one-cycle issue pulses
- rd_out_rn, rd2_out_rn  out  RN_W  destinations of the issued instruction
- inst_issued  out  1  OR of all *_en
- illegal_op  out  1  one-cycle pulse when an undecodable instruction is dropped
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Class decode at enqueue, stored per entry:
  - ALU = ~unit[2]
  - ADVINT = ~type & unit==4
  - MEM = type & unit∈{4,5,6}
  - BR = unit==7
  - type=0 with unit 5 or 6: accepted, discarded, illegal_op pulses next cycle.
- Window is a shift-compacted array; slot 0 is oldest. Enqueue writes slot count, or count-1 when an entry issues the same cycle.
- Entry i is eligible when all of the following hold:
  - Scoreboard: reg_busy[r1] and reg_busy[r2] are both clear.
  - RAW/WAW: no older valid entry's rd (or rd2 if that entry is ADVINT) equals this entry's r1, r2, rd, or rd2 (own rd2 compared only if ADVINT).
  - WAR: no older valid entry's r1/r2 equals this entry's rd (or rd2 if ADVINT).
  - Branch ordering: a BR entry is eligible only in slot 0, and no entry younger than a pending BR is eligible.
  - Memory ordering: a MEM entry is eligible only if no older MEM entry is valid.
  - Unit available: for ALU, at least one alu_busy bit is 0; for the other classes, the corresponding *_busy is 0.
- Selection: the lowest-index eligible entry issues. An ALU entry goes to the lowest-index non-busy ALU.
- Issue effects:
  - rd_out_rn <= entry rd.
  - rd2_out_rn <= entry rd2 only for ADVINT; otherwise it holds its value.
  - The entry is removed; younger entries shift down one slot.
- flush: all entries invalidated at the edge and all *_en forced 0. An in_valid at the same edge is ignored; in_ready still reflects the pre-flush count.

## Timing
- Reset values: all *_en=0, rd_out_rn=0, rd2_out_rn=0, illegal_op=0, count=0, window empty, in_ready=1.
- Enqueue at edge N; the entry is eligible for selection in cycle N+1 and *_en is asserted after edge N+1. Minimum latency is 1 cycle from acceptance to the en pulse.
- Selection is combinational on registered window state and current busy/reg_busy. Outputs are registered, so *_en pulses exactly one cycle per issued instruction.
- in_ready depends on count only: when full it stays 0 even if an issue occurs that cycle. There is no same-cycle pass-through.
- Simultaneous enqueue and issue: count is unchanged, and the new entry lands in slot count-1.
- Reset asserted mid-operation clears the window asynchronously. In-flight en pulses are dropped.

## Test plan
- Reset, then one ALU op (unit=0, r1=1, r2=2, rd=3), no busy → alu_en=2'b01 one cycle after acceptance, rd_out_rn=3, count returns to 0.
- alu_busy=2'b01, two ALU ops back-to-back → both go to alu_en[1], one per cycle as busy allows. With alu_busy=2'b11 nothing issues; count=2 holds until busy clears.
- Older op rd=5 held by memunit_busy=1, younger ALU op reading r1=5 → younger stays queued. An unrelated younger ALU op (r1=7, rd=8) issues first, demonstrating out-of-order issue.
- ADVINT op (type=0, unit=4, rd=9, rd2=10) → advint_en, rd_out_rn=9, rd2_out_rn=10. A following ALU op with rd=12 leaves rd2_out_rn at 10.
- Fill DEPTH=4 with all units busy → in_ready=0 and count=4. Assert flush → count=0 and in_ready=1 next cycle, and no en pulse.
- Enqueue BR then ALU (independent) with branch_busy=1 → neither issues. Release branch_busy → branch_en, then alu_en on the following cycle.
- type=0, unit=5 enqueued → illegal_op one-cycle pulse, count stays 0, no en.
